// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the RV32I instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        BOOT  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch for the 5-stage RV32I pipeline; stalls rely
//               on the memory holding rdataI while renI is low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] raddrI,
    output logic        renI,
    input  logic [31:0] rdataI,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pend_pc;
    logic [31:0]  w_pend_pc_next;
    logic [31:0]  w_pc_inc;
    logic         r_fault;
    logic [31:0]  r_fault_pc;
    logic [31:0]  r_count;
    logic         w_misaligned;
    logic         w_fault_set;
    logic         w_fire;

    assign w_pc_inc     = r_pend_pc + PC_STEP;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_fire       = if_valid && !stall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= START;
            r_pend_pc  <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0;
            r_count    <= 32'h0;
        end else begin
            r_state   <= w_state_next;
            r_pend_pc <= w_pend_pc_next;
            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_pc;
            end
            if (w_fire) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pend_pc_next = r_pend_pc;
        w_fault_set    = 1'b0;
        renI           = 1'b0;
        raddrI         = r_pend_pc;
        if_valid       = 1'b0;
        if_inst        = NOP_INST;

        case (r_state)
            START: begin
                w_state_next = BOOT;
            end
            BOOT: begin
                renI           = 1'b1;
                raddrI         = RESET_PC;
                w_pend_pc_next = RESET_PC;
                w_state_next   = RUN;
            end
            RUN: begin
                // The wrong-path instruction is dropped in the redirect cycle itself.
                if_valid = !redirect_valid;
                if_inst  = rdataI;
                raddrI   = w_pc_inc;
                if (redirect_valid && w_misaligned) begin
                    w_fault_set  = 1'b1;
                    w_state_next = FAULT;
                end else if (redirect_valid) begin
                    renI           = 1'b1;
                    raddrI         = redirect_pc;
                    w_pend_pc_next = redirect_pc;
                end else if (!stall_i) begin
                    renI           = 1'b1;
                    w_pend_pc_next = w_pc_inc;
                end
            end
            default: begin
                w_state_next = FAULT;
            end
        endcase
    end

    assign if_pc       = r_pend_pc;
    assign fetch_fault = r_fault;
    assign fault_pc    = r_fault_pc;
    assign fetch_count = r_count;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] raddrI;
    logic        renI;
    logic [31:0] rdataI = 32'h0;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .raddrI         (raddrI),
        .renI           (renI),
        .rdataI         (rdataI),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory contents: word index plus a fixed tag, so each address is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'h0100_0000;
    endfunction

    always @(posedge clk) begin
        if (renI) rdataI <= mem_word(raddrI);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles since reset, presented PC, dead-after-fault flag.
    int          m_age = 0;
    logic [31:0] m_pc = RST_PC;
    bit          m_dead = 0;
    bit          m_fault = 0;
    logic [31:0] m_fault_pc = 32'h0;
    logic [31:0] m_count = 32'h0;

    always @(negedge clk) begin
        bit run;
        bit bad;
        if (rst) begin
            m_age = 0; m_pc = RST_PC; m_dead = 0;
            m_fault = 0; m_fault_pc = 32'h0; m_count = 32'h0;
            chk("rst renI", {31'b0, renI}, 32'd0);
            chk("rst raddrI", raddrI, RST_PC);
            chk("rst if_valid", {31'b0, if_valid}, 32'd0);
            chk("rst if_pc", if_pc, RST_PC);
            chk("rst if_inst", if_inst, NOP);
            chk("rst fault", {31'b0, fetch_fault}, 32'd0);
            chk("rst fault_pc", fault_pc, 32'h0);
            chk("rst count", fetch_count, 32'h0);
        end else begin
            run = !m_dead && (m_age >= 2);
            bad = (redirect_pc[1:0] != 2'b00);
            chk("if_pc", if_pc, m_pc);
            chk("if_valid", {31'b0, if_valid}, {31'b0, run && !redirect_valid});
            chk("if_inst", if_inst, run ? mem_word(m_pc) : NOP);
            chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
            chk("fault_pc", fault_pc, m_fault_pc);
            chk("fetch_count", fetch_count, m_count);
            if (!run) begin
                chk("renI", {31'b0, renI}, {31'b0, (m_age == 1) && !m_dead});
                chk("raddrI", raddrI, m_pc);
            end else if (redirect_valid && bad) begin
                chk("renI", {31'b0, renI}, 32'd0);
            end else if (redirect_valid) begin
                chk("renI", {31'b0, renI}, 32'd1);
                chk("raddrI", raddrI, redirect_pc);
            end else begin
                chk("renI", {31'b0, renI}, {31'b0, !stall_i});
                chk("raddrI", raddrI, m_pc + 32'd4);
            end
            // advance model to the next cycle
            if (run) begin
                if (redirect_valid && bad) begin
                    m_dead = 1; m_fault = 1; m_fault_pc = redirect_pc;
                end else if (redirect_valid) begin
                    m_pc = redirect_pc;
                end else if (!stall_i) begin
                    m_count = m_count + 32'd1;
                    m_pc = m_pc + 32'd4;
                end
            end
            if (m_age < 2) m_age++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(); cyc();
        rst = 1'b0;                       // START cycle
        #1 chk("lit START renI", {31'b0, renI}, 32'd0);
        cyc();                            // BOOT
        chk("lit BOOT renI", {31'b0, renI}, 32'd1);
        chk("lit BOOT raddrI", raddrI, 32'h100);
        cyc();
        chk("lit pc0", if_pc, 32'h100);
        chk("lit inst0", if_inst, 32'h0100_0040);
        chk("lit valid0", {31'b0, if_valid}, 32'd1);
        cyc();
        chk("lit pc1", if_pc, 32'h104);
        cyc();
        chk("lit pc2", if_pc, 32'h108);
        chk("lit inst2", if_inst, 32'h0100_0042);
        stall_i = 1'b1;
        #1 chk("lit stall renI", {31'b0, renI}, 32'd0);
        cyc(); cyc(); cyc();
        stall_i = 1'b0;
        chk("lit stall pc", if_pc, 32'h108);
        chk("lit stall count", fetch_count, 32'd2);
        cyc();
        chk("lit after stall pc", if_pc, 32'h10C);
        chk("lit after stall count", fetch_count, 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1 chk("lit redir kill", {31'b0, if_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        chk("lit redir pc", if_pc, 32'h200);
        cyc();
        chk("lit redir pc+4", if_pc, 32'h204);
        stall_i = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        #1 chk("lit rs renI", {31'b0, renI}, 32'd1);
        chk("lit rs raddrI", raddrI, 32'h300);
        cyc();
        stall_i = 1'b0; redirect_valid = 1'b0;
        chk("lit rs pc", if_pc, 32'h300);
        chk("lit rs inst", if_inst, 32'h0100_00C0);
        cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        #1 chk("lit mis renI", {31'b0, renI}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        chk("lit fault", {31'b0, fetch_fault}, 32'd1);
        chk("lit fault_pc", fault_pc, 32'h202);
        for (int i = 0; i < 4; i++) begin
            stall_i = i[0]; redirect_valid = i[1]; redirect_pc = 32'h400;
            cyc();
            chk("lit fault valid", {31'b0, if_valid}, 32'd0);
            chk("lit fault renI", {31'b0, renI}, 32'd0);
        end
        stall_i = 1'b0; redirect_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        #2 rst = 1'b1;                    // between edges
        #1 chk("lit async renI", {31'b0, renI}, 32'd0);
        chk("lit async if_valid", {31'b0, if_valid}, 32'd0);
        chk("lit async if_pc", if_pc, RST_PC);
        chk("lit async count", fetch_count, 32'd0);
        chk("lit async inst", if_inst, NOP);
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
